// File: rtl/tmr_voter_fsm_if.sv
// tmr_voter_fsm_if: bundle, status and resync handshake between a TMR core group and its voter.
// Optional error-log counters appear only when TMR_ERR_LOG_EN is defined.
interface tmr_voter_fsm_if #(
  parameter int DATA_W = 32
`ifdef TMR_ERR_LOG_EN
  , parameter int CNT_W = 8
`endif
);
  logic              in_valid;
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [DATA_W-1:0] bus_c;
  logic [DATA_W-1:0] bus_out;
  logic              out_valid;
  logic [1:0]        mode;
  logic [2:0]        core_fail;
  logic              resync_req;
  logic [1:0]        resync_id;
  logic              resync_ack;
  logic              fatal;
`ifdef TMR_ERR_LOG_EN
  logic [CNT_W-1:0]  err_cnt_a;
  logic [CNT_W-1:0]  err_cnt_b;
  logic [CNT_W-1:0]  err_cnt_c;
`endif
  modport master (
    output in_valid, bus_a, bus_b, bus_c, resync_ack,
    input  bus_out, out_valid, mode, core_fail, resync_req, resync_id, fatal
`ifdef TMR_ERR_LOG_EN
    , input err_cnt_a, err_cnt_b, err_cnt_c
`endif
  );
  modport slave (
    input  in_valid, bus_a, bus_b, bus_c, resync_ack,
    output bus_out, out_valid, mode, core_fail, resync_req, resync_id, fatal
`ifdef TMR_ERR_LOG_EN
    , output err_cnt_a, err_cnt_b, err_cnt_c
`endif
  );
endinterface

// File: rtl/tmr_voter_fsm.sv
// tmr_voter_fsm: stateful TMR majority voter that retires a persistently failing core and degrades to duplex.
// Define TMR_ERR_LOG_EN to add saturating per-lane mismatch counters.
module tmr_voter_fsm #(
  parameter int DATA_W      = 32,
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tmr_voter_fsm_if.slave    bus
);
  localparam logic [1:0] S_TMR   = 2'b00;
  localparam logic [1:0] S_DUP   = 2'b01;
  localparam logic [1:0] S_FATAL = 2'b10;
  localparam int TW = $clog2(FAIL_THRESH + 1);
  if (FAIL_THRESH < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("tmr_voter_fsm: FAIL_THRESH and CNT_W must be >= 1");
  end
  logic [DATA_W-1:0] lane [3];
  logic [DATA_W-1:0] maj, h_lo, h_hi, voted;
  logic [DATA_W-1:0] out_q, out_d;
  logic [1:0]        mode_q, mode_d, id_q, id_d, nhit;
  logic [2:0]        fail_q, fail_d, mis, hit;
  logic              req_q, req_d, ov_q, dup_split;
  logic [TW-1:0]     cnt_q [3];
  logic [TW-1:0]     cnt_d [3];
  assign lane[0]   = bus.bus_a;
  assign lane[1]   = bus.bus_b;
  assign lane[2]   = bus.bus_c;
  assign maj       = (lane[0] & lane[1]) | (lane[1] & lane[2]) | (lane[0] & lane[2]);
  // Healthy pair while duplex: the two lanes other than the retired one, lowest index first.
  assign h_lo      = (id_q == 2'd0) ? lane[1] : lane[0];
  assign h_hi      = (id_q == 2'd2) ? lane[1] : lane[2];
  assign dup_split = h_lo != h_hi;
  assign voted     = (mode_q == S_TMR) ? maj : (mode_q == S_DUP) ? h_lo : out_q;
  assign nhit      = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mis[i] = lane[i] != voted;
      hit[i] = (mode_q == S_TMR) && mis[i] && (int'(cnt_q[i]) + 1 >= FAIL_THRESH);
    end
  end
  always_comb begin
    mode_d = mode_q;
    out_d  = out_q;
    fail_d = fail_q;
    req_d  = req_q;
    id_d   = id_q;
    cnt_d  = cnt_q;
    if (bus.in_valid && mode_q == S_TMR) begin
      out_d = maj;
      for (int i = 0; i < 3; i++) cnt_d[i] = mis[i] ? cnt_q[i] + 1'b1 : '0;
      if (nhit > 2'd1) begin
        mode_d = S_FATAL;
      end else if (nhit == 2'd1) begin
        mode_d = S_DUP;
        fail_d = hit;
        req_d  = 1'b1;
        id_d   = hit[0] ? 2'd0 : hit[1] ? 2'd1 : 2'd2;
      end
    end else if (bus.in_valid && mode_q == S_DUP) begin
      out_d  = dup_split ? out_q : h_lo;
      mode_d = dup_split ? S_FATAL : S_DUP;
      for (int i = 0; i < 3; i++) cnt_d[i] = '0;
    end
    // Ack completes the reload unless the same sample already broke duplex agreement.
    if (mode_q == S_DUP && mode_d != S_FATAL && req_q && bus.resync_ack) begin
      fail_d[id_q] = 1'b0;
      cnt_d[id_q]  = '0;
      mode_d       = S_TMR;
      req_d        = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= S_TMR;
      out_q  <= '0;
      fail_q <= '0;
      req_q  <= 1'b0;
      id_q   <= '0;
      ov_q   <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      fail_q <= fail_d;
      req_q  <= req_d;
      id_q   <= id_d;
      ov_q   <= bus.in_valid;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign bus.bus_out    = out_q;
  assign bus.out_valid  = ov_q;
  assign bus.mode       = mode_q;
  assign bus.core_fail  = fail_q;
  assign bus.resync_req = req_q;
  assign bus.resync_id  = id_q;
  assign bus.fatal      = mode_q == S_FATAL;
`ifdef TMR_ERR_LOG_EN
  logic [CNT_W-1:0] err_q [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) err_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (bus.in_valid && mis[i] && err_q[i] != '1) err_q[i] <= err_q[i] + 1'b1;
    end
  end
  assign bus.err_cnt_a = err_q[0];
  assign bus.err_cnt_b = err_q[1];
  assign bus.err_cnt_c = err_q[2];
`endif
endmodule
